// File: rtl/leaf_rx_port.sv
// leaf_rx_port: receive endpoint of the leaf/user stream protocol.
// Buffers in-order data payloads addressed to PORT_ID in a first-word-fall-through FIFO.
// Hands them to the user over vld/ack.
// Returns a freespace credit packet upstream every FREESPACE_UPDATE_SIZE consumed words.
module leaf_rx_port #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 4,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int PORT_ID               = 2,
    parameter int UPSTREAM_LEAF         = 1,
    parameter int UPSTREAM_PORT         = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
    input  logic                    resend,
    output logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
    output logic                    vld_interface2user,
    input  logic                    ack_user2interface,
    output logic                    seq_err,
    output logic                    overflow
);

    localparam int DEPTH   = 1 << NUM_BRAM_ADDR_BITS;
    localparam int PTR_W   = NUM_BRAM_ADDR_BITS + 1;
    localparam int CREDIT_W = $clog2(FREESPACE_UPDATE_SIZE + 1);

    localparam int TYPE_BIT  = PAYLOAD_BITS;
    localparam int SEQ_LSB   = PAYLOAD_BITS + 1;
    localparam int PORT_LSB  = SEQ_LSB + NUM_ADDR_BITS;
    localparam int VALID_BIT = PACKET_BITS - 1;

    localparam logic [PTR_W-1:0]         FULL_COUNT  = PTR_W'(DEPTH);
    localparam logic [CREDIT_W-1:0]      CREDIT_LAST = CREDIT_W'(FREESPACE_UPDATE_SIZE - 1);
    localparam logic [NUM_PORT_BITS-1:0] MY_PORT     = NUM_PORT_BITS'(PORT_ID);

    logic [PAYLOAD_BITS-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         count;
    logic [NUM_ADDR_BITS-1:0] expected_seq;
    logic [CREDIT_W-1:0]      credit_cnt;
    logic [NUM_ADDR_BITS-1:0] credit_seq;
    logic [PACKET_BITS-1:0]   last_credit;

    logic                     accept;
    logic                     full;
    logic                     seq_ok;
    logic                     wr_en;
    logic                     pop;
    logic                     credit_due;
    logic [PACKET_BITS-1:0]   credit_pkt;

    // Decode ingress packet, FIFO status and the credit packet that would be sent this cycle.
    always_comb begin
        accept     = din_leaf_bft2interface[VALID_BIT]
                     && !din_leaf_bft2interface[TYPE_BIT]
                     && (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == MY_PORT);
        full       = (count == FULL_COUNT);
        seq_ok     = (din_leaf_bft2interface[SEQ_LSB +: NUM_ADDR_BITS] == expected_seq);
        wr_en      = accept && !full && seq_ok;
        vld_interface2user = (count != '0);
        pop        = vld_interface2user && ack_user2interface;
        credit_due = pop && (credit_cnt == CREDIT_LAST);
        credit_pkt = {1'b1,
                      NUM_LEAF_BITS'(UPSTREAM_LEAF),
                      NUM_PORT_BITS'(UPSTREAM_PORT),
                      credit_seq,
                      1'b1,
                      PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};
        dout_leaf_interface2user = vld_interface2user ? mem[rd_ptr[NUM_BRAM_ADDR_BITS-1:0]] : '0;
    end

    // Payload storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[NUM_BRAM_ADDR_BITS-1:0]] <= din_leaf_bft2interface[PAYLOAD_BITS-1:0];
        end
    end

    // FIFO pointers, occupancy, sequence tracking and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            expected_seq <= '0;
            seq_err      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr       <= wr_ptr + 1'b1;
                expected_seq <= expected_seq + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end
            if (accept && full) begin
                overflow <= 1'b1;
            end else if (accept && !seq_ok) begin
                seq_err <= 1'b1;
            end
        end
    end

    // Credit counting and the one-cycle credit/resend output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_cnt              <= '0;
            credit_seq              <= '0;
            last_credit             <= '0;
            dout_leaf_interface2bft <= '0;
        end else begin
            dout_leaf_interface2bft <= '0;
            if (credit_due) begin
                credit_cnt              <= '0;
                credit_seq              <= credit_seq + 1'b1;
                last_credit             <= credit_pkt;
                dout_leaf_interface2bft <= credit_pkt;
            end else begin
                if (pop) begin
                    credit_cnt <= credit_cnt + 1'b1;
                end
                if (resend) begin
                    dout_leaf_interface2bft <= last_credit;
                end
            end
        end
    end

endmodule
